// File: rtl/mem_rq_client_if.sv
// Command, memory get/put and result signals of mem_rq_client.
// The slave modport is the client itself; master is the side facing it.
interface mem_rq_client_if #(
    parameter int MAX_OUTSTANDING = 2
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_addr;
    logic          cmd_iswrite;
    logic [31:0]   cmd_data;
    logic [64:0]   obtain_rq_get;
    logic          RDY_obtain_rq_get;
    logic          EN_obtain_rq_get;
    logic [31:0]   send_rs_put;
    logic          EN_send_rs_put;
    logic          RDY_send_rs_put;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [31:0]   rsp_addr;
    logic          rsp_iswrite;
    logic [OW-1:0] outstanding;
    logic          proto_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_iswrite, cmd_data,
        output EN_obtain_rq_get, send_rs_put, EN_send_rs_put, rsp_ready,
        input  cmd_ready, obtain_rq_get, RDY_obtain_rq_get, RDY_send_rs_put,
        input  rsp_valid, rsp_data, rsp_addr, rsp_iswrite, outstanding, proto_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_iswrite, cmd_data,
        input  EN_obtain_rq_get, send_rs_put, EN_send_rs_put, rsp_ready,
        output cmd_ready, obtain_rq_get, RDY_obtain_rq_get, RDY_send_rs_put,
        output rsp_valid, rsp_data, rsp_addr, rsp_iswrite, outstanding, proto_err
    );
endinterface

// File: rtl/mem_rq_client.sv
// Memory request initiator: command queue -> Get-side requests, Put-side
// responses matched in issue order against a tag FIFO -> result queue.
module mem_rq_client #(
    parameter int RQ_DEPTH        = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RSP_DEPTH       = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    mem_rq_client_if.slave  bus
);
    localparam int RQ_AW  = $clog2(RQ_DEPTH);
    localparam int RS_AW  = $clog2(RSP_DEPTH);
    localparam int TAG_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW     = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [RQ_AW:0]    RQ_FULL  = (RQ_AW + 1)'(RQ_DEPTH);
    localparam logic [RS_AW:0]    RS_FULL  = (RS_AW + 1)'(RSP_DEPTH);
    localparam logic [OW-1:0]     OUT_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [TAG_AW-1:0] TAG_LAST = TAG_AW'(MAX_OUTSTANDING - 1);

    logic [64:0]       rq_mem [RQ_DEPTH];
    logic [RQ_AW-1:0]  rq_wr, rq_rd;
    logic [RQ_AW:0]    rq_cnt;
    logic [32:0]       tag_mem [MAX_OUTSTANDING];
    logic [TAG_AW-1:0] tag_wr, tag_rd;
    logic [OW-1:0]     outst;
    logic [64:0]       rs_mem [RSP_DEPTH];
    logic [RS_AW-1:0]  rs_wr, rs_rd;
    logic [RS_AW:0]    rs_cnt;
    logic              err_q;

    logic        rq_empty, rq_full, rdy_get, rdy_put;
    logic        do_push, do_get, do_put, do_pop, bypass, tag_push, tag_pop, err_now;
    logic [64:0] rq_head;
    logic [32:0] put_tag;

    assign rq_empty = (rq_cnt == '0);
    assign rq_full  = (rq_cnt == RQ_FULL);
    assign rq_head  = rq_mem[rq_rd];
    assign rdy_get  = !rq_empty && (outst < OUT_MAX);
    assign rdy_put  = (rs_cnt < RS_FULL) && ((outst != '0) || rdy_get);

    assign do_push  = bus.cmd_valid && !rq_full;
    assign do_get   = bus.EN_obtain_rq_get && rdy_get;
    assign do_put   = bus.EN_send_rs_put && rdy_put && ((outst != '0) || do_get);
    assign do_pop   = (rs_cnt != '0) && bus.rsp_ready;
    assign err_now  = (bus.EN_obtain_rq_get && !rdy_get) || (bus.EN_send_rs_put && !do_put);

    // Zero-latency answer: the tag comes straight from the request being issued.
    assign bypass   = do_put && (outst == '0);
    assign tag_push = do_get && !bypass;
    assign tag_pop  = do_put && !bypass;
    assign put_tag  = bypass ? rq_head[64:32] : tag_mem[tag_rd];

    always_ff @(posedge CLK) begin
        if (do_push) rq_mem[rq_wr]   <= {bus.cmd_addr, bus.cmd_iswrite, bus.cmd_data};
        if (tag_push) tag_mem[tag_wr] <= rq_head[64:32];
        if (do_put) rs_mem[rs_wr]    <= {bus.send_rs_put, put_tag};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rq_wr  <= '0;
            rq_rd  <= '0;
            rq_cnt <= '0;
            tag_wr <= '0;
            tag_rd <= '0;
            outst  <= '0;
            rs_wr  <= '0;
            rs_rd  <= '0;
            rs_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (do_push) rq_wr <= rq_wr + RQ_AW'(1);
            if (do_get)  rq_rd <= rq_rd + RQ_AW'(1);
            if (do_push && !do_get)      rq_cnt <= rq_cnt + (RQ_AW + 1)'(1);
            else if (!do_push && do_get) rq_cnt <= rq_cnt - (RQ_AW + 1)'(1);

            if (tag_push) tag_wr <= (tag_wr == TAG_LAST) ? '0 : tag_wr + TAG_AW'(1);
            if (tag_pop)  tag_rd <= (tag_rd == TAG_LAST) ? '0 : tag_rd + TAG_AW'(1);
            if (tag_push && !tag_pop)      outst <= outst + OW'(1);
            else if (!tag_push && tag_pop) outst <= outst - OW'(1);

            if (do_put) rs_wr <= rs_wr + RS_AW'(1);
            if (do_pop) rs_rd <= rs_rd + RS_AW'(1);
            if (do_put && !do_pop)      rs_cnt <= rs_cnt + (RS_AW + 1)'(1);
            else if (!do_put && do_pop) rs_cnt <= rs_cnt - (RS_AW + 1)'(1);

            if (err_now) err_q <= 1'b1;
        end
    end

    assign bus.cmd_ready         = !rq_full;
    assign bus.obtain_rq_get     = rq_empty ? '0 : rq_head;
    assign bus.RDY_obtain_rq_get = rdy_get;
    assign bus.RDY_send_rs_put   = rdy_put;
    assign bus.rsp_valid         = (rs_cnt != '0);
    assign {bus.rsp_data, bus.rsp_addr, bus.rsp_iswrite} =
        (rs_cnt != '0) ? rs_mem[rs_rd] : '0;
    assign bus.outstanding       = outst;
    assign bus.proto_err         = err_q;
endmodule

// File: tb/tb_mem_rq_client.sv
// Directed bench for mem_rq_client: reset, read, write, outstanding limit,
// result backpressure and protocol-violation handling.
module tb_mem_rq_client;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   put_k = 0;

    mem_rq_client_if #(.MAX_OUTSTANDING(2)) bus ();

    mem_rq_client #(.RQ_DEPTH(2), .MAX_OUTSTANDING(2), .RSP_DEPTH(2)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cmd_valid        = 1'b0;
        bus.cmd_addr         = '0;
        bus.cmd_iswrite      = 1'b0;
        bus.cmd_data         = '0;
        bus.EN_obtain_rq_get = 1'b0;
        bus.EN_send_rs_put   = 1'b0;
        bus.send_rs_put      = '0;
        bus.rsp_ready        = 1'b0;
    endtask

    task automatic push_cmd(input logic [31:0] addr, input logic wr, input logic [31:0] data);
        bus.cmd_valid   = 1'b1;
        bus.cmd_addr    = addr;
        bus.cmd_iswrite = wr;
        bus.cmd_data    = data;
        tick();
        bus.cmd_valid   = 1'b0;
    endtask

    task automatic test_reset;
        push_cmd(32'h55, 1'b0, 32'h0);
        checks++;
        if (bus.RDY_obtain_rq_get !== 1'b1) begin
            fails++; $display("FAIL pre_reset_rdy_get: got %b want 1", bus.RDY_obtain_rq_get);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_ready, bus.RDY_obtain_rq_get, bus.RDY_send_rs_put, bus.rsp_valid, bus.proto_err} !== 5'b10000) begin
            fails++; $display("FAIL reset_flags: got %b want 10000",
                {bus.cmd_ready, bus.RDY_obtain_rq_get, bus.RDY_send_rs_put, bus.rsp_valid, bus.proto_err});
        end
        checks++;
        if (bus.obtain_rq_get !== 65'h0 || bus.outstanding !== 2'd0) begin
            fails++; $display("FAIL reset_get_outst: got %h/%0d want 0/0", bus.obtain_rq_get, bus.outstanding);
        end
        checks++;
        if ({bus.rsp_data, bus.rsp_addr, bus.rsp_iswrite} !== 65'h0) begin
            fails++; $display("FAIL reset_rsp_fields: got %h want 0", {bus.rsp_data, bus.rsp_addr, bus.rsp_iswrite});
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        push_cmd(32'h10, 1'b0, 32'h0);
        checks++;
        if (bus.RDY_obtain_rq_get !== 1'b1 || bus.RDY_send_rs_put !== 1'b1) begin
            fails++; $display("FAIL read_rdy: got get=%b put=%b want 1/1", bus.RDY_obtain_rq_get, bus.RDY_send_rs_put);
        end
        checks++;
        if (bus.obtain_rq_get !== {32'h10, 1'b0, 32'h0}) begin
            fails++; $display("FAIL read_get_word: got %h want %h", bus.obtain_rq_get, {32'h10, 1'b0, 32'h0});
        end
        bus.EN_obtain_rq_get = 1'b1;
        bus.EN_send_rs_put   = 1'b1;
        bus.send_rs_put      = 32'h13;
        tick();
        bus.EN_obtain_rq_get = 1'b0;
        bus.EN_send_rs_put   = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_addr, bus.rsp_iswrite} !== {1'b1, 32'h13, 32'h10, 1'b0}) begin
            fails++; $display("FAIL read_result: got v=%b d=%h a=%h w=%b want 1/13/10/0",
                bus.rsp_valid, bus.rsp_data, bus.rsp_addr, bus.rsp_iswrite);
        end
        checks++;
        if (bus.outstanding !== 2'd0 || bus.proto_err !== 1'b0) begin
            fails++; $display("FAIL read_outst: got %0d err=%b want 0/0", bus.outstanding, bus.proto_err);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            fails++; $display("FAIL read_drain: got %b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_write;
        push_cmd(32'h400, 1'b1, 32'h1234_5678);
        checks++;
        if (bus.obtain_rq_get !== 65'h801_1234_5678) begin
            fails++; $display("FAIL write_get_word: got %h want 80112345678", bus.obtain_rq_get);
        end
        bus.EN_obtain_rq_get = 1'b1;
        tick();
        bus.EN_obtain_rq_get = 1'b0;
        checks++;
        if (bus.outstanding !== 2'd1 || bus.rsp_valid !== 1'b0 || bus.RDY_send_rs_put !== 1'b1) begin
            fails++; $display("FAIL write_issued: got outst=%0d v=%b rdy_put=%b want 1/0/1",
                bus.outstanding, bus.rsp_valid, bus.RDY_send_rs_put);
        end
        bus.EN_send_rs_put = 1'b1;
        bus.send_rs_put    = 32'hDEAD_BEEF;
        tick();
        bus.EN_send_rs_put = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_addr, bus.rsp_iswrite, bus.outstanding} !==
            {1'b1, 32'hDEAD_BEEF, 32'h400, 1'b1, 2'd0}) begin
            fails++; $display("FAIL write_result: got v=%b d=%h a=%h w=%b o=%0d want 1/deadbeef/400/1/0",
                bus.rsp_valid, bus.rsp_data, bus.rsp_addr, bus.rsp_iswrite, bus.outstanding);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_outstanding_limit;
        bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h0; bus.cmd_iswrite = 1'b0; bus.cmd_data = '0;
        tick();
        bus.cmd_addr = 32'h4; bus.EN_obtain_rq_get = 1'b1;
        tick();
        bus.cmd_addr = 32'h8;
        tick();
        bus.cmd_valid = 1'b0; bus.EN_obtain_rq_get = 1'b0;
        checks++;
        if (bus.outstanding !== 2'd2 || bus.RDY_obtain_rq_get !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            fails++; $display("FAIL limit_reached: got o=%0d rdy_get=%b cmd_ready=%b want 2/0/1",
                bus.outstanding, bus.RDY_obtain_rq_get, bus.cmd_ready);
        end
        checks++;
        if (bus.obtain_rq_get !== {32'h8, 1'b0, 32'h0}) begin
            fails++; $display("FAIL limit_head: got %h want %h", bus.obtain_rq_get, {32'h8, 1'b0, 32'h0});
        end
        bus.EN_send_rs_put = 1'b1; bus.send_rs_put = 32'hA0;
        tick();
        bus.EN_send_rs_put = 1'b0;
        checks++;
        if (bus.outstanding !== 2'd1 || bus.RDY_obtain_rq_get !== 1'b1) begin
            fails++; $display("FAIL limit_release: got o=%0d rdy_get=%b want 1/1", bus.outstanding, bus.RDY_obtain_rq_get);
        end
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_addr} !== {1'b1, 32'hA0, 32'h0}) begin
            fails++; $display("FAIL limit_rsp0: got v=%b d=%h a=%h want 1/a0/0", bus.rsp_valid, bus.rsp_data, bus.rsp_addr);
        end
        bus.EN_obtain_rq_get = 1'b1; bus.rsp_ready = 1'b1;
        tick();
        bus.EN_obtain_rq_get = 1'b0; bus.rsp_ready = 1'b0;
        checks++;
        if (bus.outstanding !== 2'd2 || bus.rsp_valid !== 1'b0) begin
            fails++; $display("FAIL limit_third_issue: got o=%0d v=%b want 2/0", bus.outstanding, bus.rsp_valid);
        end
        bus.EN_send_rs_put = 1'b1; bus.send_rs_put = 32'hA4;
        tick();
        checks++;
        if ({bus.rsp_data, bus.rsp_addr, bus.outstanding} !== {32'hA4, 32'h4, 2'd1}) begin
            fails++; $display("FAIL limit_rsp1: got d=%h a=%h o=%0d want a4/4/1", bus.rsp_data, bus.rsp_addr, bus.outstanding);
        end
        bus.send_rs_put = 32'hA8; bus.rsp_ready = 1'b1;
        tick();
        bus.EN_send_rs_put = 1'b0;
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_addr, bus.outstanding} !== {1'b1, 32'hA8, 32'h8, 2'd0}) begin
            fails++; $display("FAIL limit_rsp2: got v=%b d=%h a=%h o=%0d want 1/a8/8/0",
                bus.rsp_valid, bus.rsp_data, bus.rsp_addr, bus.outstanding);
        end
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int  sent = 0;
        int  got = 0;
        logic accept, was_put;
        put_k = 0;
        bus.rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.cmd_valid   = (sent < 6);
            bus.cmd_addr    = 32'h1000 + 32'(4 * sent);
            bus.cmd_iswrite = sent[0];
            bus.cmd_data    = 32'h5000 + 32'(sent);
            accept = bus.cmd_valid && bus.cmd_ready;
            bus.EN_obtain_rq_get = bus.RDY_obtain_rq_get;
            bus.EN_send_rs_put   = bus.RDY_send_rs_put;
            bus.send_rs_put      = 32'h100 + 32'(put_k);
            was_put = bus.EN_send_rs_put;
            tick();
            if (accept) sent++;
            if (was_put) put_k++;
        end
        checks++;
        if (sent != 6 || put_k != 2) begin
            fails++; $display("FAIL bp_accepted: got sent=%0d puts=%0d want 6/2", sent, put_k);
        end
        checks++;
        if ({bus.RDY_send_rs_put, bus.cmd_ready, bus.RDY_obtain_rq_get, bus.rsp_valid, bus.outstanding} !== {4'b0001, 2'd2}) begin
            fails++; $display("FAIL bp_stalled: got rdy_put=%b cmd_ready=%b rdy_get=%b v=%b o=%0d want 0/0/0/1/2",
                bus.RDY_send_rs_put, bus.cmd_ready, bus.RDY_obtain_rq_get, bus.rsp_valid, bus.outstanding);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
            bus.EN_obtain_rq_get = bus.RDY_obtain_rq_get;
            bus.EN_send_rs_put   = bus.RDY_send_rs_put;
            bus.send_rs_put      = 32'h100 + 32'(put_k);
            was_put = bus.EN_send_rs_put;
            if (bus.rsp_valid === 1'b1) begin
                checks++;
                if ({bus.rsp_data, bus.rsp_addr, bus.rsp_iswrite} !==
                    {32'h100 + 32'(got), 32'h1000 + 32'(4 * got), got[0]}) begin
                    fails++; $display("FAIL bp_result%0d: got d=%h a=%h w=%b want d=%h a=%h w=%b", got,
                        bus.rsp_data, bus.rsp_addr, bus.rsp_iswrite, 32'h100 + 32'(got), 32'h1000 + 32'(4 * got), got[0]);
                end
                got++;
            end
            tick();
            if (was_put) put_k++;
        end
        idle_inputs();
        checks++;
        if (got != 6 || bus.rsp_valid !== 1'b0 || bus.outstanding !== 2'd0) begin
            fails++; $display("FAIL bp_drained: got results=%0d v=%b o=%0d want 6/0/0", got, bus.rsp_valid, bus.outstanding);
        end
    endtask

    task automatic test_proto_err;
        bus.EN_send_rs_put = 1'b1; bus.send_rs_put = 32'h77;
        tick();
        bus.EN_send_rs_put = 1'b0;
        checks++;
        if ({bus.proto_err, bus.rsp_valid, bus.outstanding} !== {2'b10, 2'd0}) begin
            fails++; $display("FAIL err_orphan_put: got err=%b v=%b o=%0d want 1/0/0", bus.proto_err, bus.rsp_valid, bus.outstanding);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.proto_err !== 1'b0) begin
            fails++; $display("FAIL err_cleared: got %b want 0", bus.proto_err);
        end
        #1 rst_n = 1'b1;
        tick();
        bus.EN_obtain_rq_get = 1'b1;
        tick();
        bus.EN_obtain_rq_get = 1'b0;
        checks++;
        if (bus.proto_err !== 1'b1 || bus.outstanding !== 2'd0) begin
            fails++; $display("FAIL err_get_empty: got err=%b o=%0d want 1/0", bus.proto_err, bus.outstanding);
        end
        push_cmd(32'h20, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        bus.EN_send_rs_put = 1'b1;
        tick();
        bus.EN_send_rs_put = 1'b0;
        checks++;
        if ({bus.proto_err, bus.rsp_valid, bus.RDY_obtain_rq_get} !== 3'b100) begin
            fails++; $display("FAIL err_after_reset: got err=%b v=%b rdy_get=%b want 1/0/0",
                bus.proto_err, bus.rsp_valid, bus.RDY_obtain_rq_get);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_single_read();
        test_write();
        test_outstanding_limit();
        test_backpressure();
        test_proto_err();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
